// File: rtl/pmp_csr_unit_if.sv
// Decoded PMP entry bundle shared between the CSR unit (master) and the PMP checkers (slave).
interface pmp_csr_unit_if #(
  parameter int unsigned NPHYS   = 56,
  parameter int unsigned NUM_PMP = 5
);
  localparam int unsigned AW = NPHYS - 2;

  logic [NUM_PMP-1:0]         valid;
  logic [NUM_PMP-1:0][AW-1:0] start;
  logic [NUM_PMP-1:0][AW-1:0] aend;
  logic [NUM_PMP-1:0][2:0]    prot;
  logic [NUM_PMP-1:0]         locked;

  modport master (output valid, output start, output aend, output prot, output locked);
  modport slave  (input  valid, input  start, input  aend, input  prot, input  locked);
endinterface

// File: rtl/pmp_csr_unit.sv
// pmpcfg/pmpaddr CSR storage with a sequential per-entry decode sweep into word ranges.
// Optional feature: define PMP_TOR_EN to support TOR mode (otherwise A=1 stores as OFF).
module pmp_csr_unit #(
  parameter int unsigned NPHYS   = 56,
  parameter int unsigned NUM_PMP = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csr_wr,
  input  logic [11:0]           csr_addr,
  input  logic [63:0]           csr_wdata,
  output logic [63:0]           csr_rdata,
  output logic                  pmp_busy,
  pmp_csr_unit_if.master        pmp
);
  localparam int unsigned AW = NPHYS - 2;
  localparam int unsigned IW = $clog2(NUM_PMP) + 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    cfg  [NUM_PMP];
  logic [AW-1:0] addr [NUM_PMP];

  logic                sweep_req;
  logic [NUM_PMP-1:0]  addr_lock;
  logic [7:0]          dec_cfg;
  logic [AW-1:0]       dec_addr, dec_prev, dec_mask;
  logic [AW-1:0]       dec_start, dec_aend;
  logic                dec_valid;

  function automatic logic [7:0] warl_cfg(input logic [7:0] w);
    logic [7:0] r;
    r      = w;
    r[6:5] = 2'b00;
    if (!w[0] && w[1]) r[1] = 1'b0;
`ifndef PMP_TOR_EN
    if (w[4:3] == 2'b01) r[4:3] = 2'b00;
`endif
    return r;
  endfunction

  assign sweep_req = csr_wr && (csr_addr == 12'h3a0 || csr_addr == 12'h3a2 ||
                                csr_addr[11:4] == 8'h3b);

  // An address is frozen by its own lock, or by a locked TOR entry above that uses it as base.
  always_comb begin
    addr_lock = '0;
    for (int i = 0; i < int'(NUM_PMP); i++) addr_lock[i] = cfg[i][7];
`ifdef PMP_TOR_EN
    for (int i = 0; i < int'(NUM_PMP) - 1; i++)
      if (cfg[i+1][7] && cfg[i+1][4:3] == 2'b01) addr_lock[i] = 1'b1;
`endif
  end

  always_comb begin
    csr_rdata = '0;
    for (int i = 0; i < int'(NUM_PMP); i++) begin
      if (csr_addr == ((i < 8) ? 12'h3a0 : 12'h3a2)) csr_rdata[8*(i%8) +: 8] = cfg[i];
      if (csr_addr == 12'(12'h3b0 + i)) csr_rdata = 64'(addr[i]);
    end
  end

  // CSR storage; lock checks use pre-write state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_PMP); i++) begin
        cfg[i]  <= '0;
        addr[i] <= '0;
      end
    end else if (csr_wr) begin
      for (int i = 0; i < int'(NUM_PMP); i++) begin
        if (csr_addr == ((i < 8) ? 12'h3a0 : 12'h3a2) && !cfg[i][7])
          cfg[i] <= warl_cfg(csr_wdata[8*(i%8) +: 8]);
        if (csr_addr == 12'(12'h3b0 + i) && !addr_lock[i])
          addr[i] <= csr_wdata[AW-1:0];
      end
    end
  end

  // Select the entry under decode and its TOR base.
  always_comb begin
    dec_cfg  = '0;
    dec_addr = '0;
    dec_prev = '0;
    for (int i = 0; i < int'(NUM_PMP); i++)
      if (idx == IW'(i)) begin
        dec_cfg  = cfg[i];
        dec_addr = addr[i];
      end
    for (int i = 1; i < int'(NUM_PMP); i++)
      if (idx == IW'(i)) dec_prev = addr[i-1];
  end

  always_comb begin
    dec_mask  = dec_addr ^ (dec_addr + AW'(1));
    dec_start = '0;
    dec_aend  = '0;
    dec_valid = 1'b0;
    case (dec_cfg[4:3])
`ifdef PMP_TOR_EN
      2'b01: begin
        dec_start = dec_prev;
        dec_aend  = dec_addr - AW'(1);
        dec_valid = dec_addr > dec_prev;
      end
`endif
      2'b10: begin
        dec_start = dec_addr;
        dec_aend  = dec_addr;
        dec_valid = 1'b1;
      end
      2'b11: begin
        dec_start = dec_addr & ~dec_mask;
        dec_aend  = dec_addr | dec_mask;
        dec_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Sweep FSM; any write restarts from entry 0 so no stale decode survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      pmp_busy   <= 1'b0;
      pmp.valid  <= '0;
      pmp.start  <= '0;
      pmp.aend   <= '0;
      pmp.prot   <= '0;
      pmp.locked <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sweep_req) begin
            state    <= SWEEP;
            idx      <= '0;
            pmp_busy <= 1'b1;
          end
        end
        SWEEP: begin
          for (int i = 0; i < int'(NUM_PMP); i++)
            if (idx == IW'(i)) begin
              pmp.valid[i]  <= dec_valid;
              pmp.start[i]  <= dec_start;
              pmp.aend[i]   <= dec_aend;
              pmp.prot[i]   <= dec_cfg[2:0];
              pmp.locked[i] <= dec_cfg[7];
            end
          if (sweep_req) begin
            idx <= '0;
          end else if (idx == IW'(NUM_PMP - 1)) begin
            state    <= IDLE;
            idx      <= '0;
            pmp_busy <= 1'b0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
